// File: rtl/sample_decim.sv
// sample_decim
// Decimates a qualified 8-bit sample stream. One out of every DIV+1 valid
// samples is accepted, starting with the first valid sample after reset.
// The accept strobe is combinational and the sample is passed straight
// through. The FIFO can therefore capture an accepted sample on the same
// edge that it arrives.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   SAMPLE       incoming sample byte
//   SAMPLE_VALID one-cycle strobe qualifying SAMPLE
//   DIV          decimation ratio (accept 1 of DIV+1, 0 = accept all)
//   accepted     high in the cycle a valid sample is taken
//   sample_out   the sample byte (pass-through of SAMPLE)
module sample_decim #(
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       SAMPLE,
    input  logic             SAMPLE_VALID,
    input  logic [DIV_W-1:0] DIV,
    output logic             accepted,
    output logic [7:0]       sample_out
);

    logic [DIV_W-1:0] dcnt;

    // The counter reaching zero marks the next valid sample as the one to keep.
    assign accepted   = SAMPLE_VALID && (dcnt == '0);
    assign sample_out = SAMPLE;

    // DIV is only sampled on reload, so a new ratio never truncates the
    // skip run that is already in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dcnt <= '0;
        end else if (SAMPLE_VALID) begin
            if (dcnt == '0) begin
                dcnt <= DIV;
            end else begin
                dcnt <= dcnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/val_sample_fifo.sv
// val_sample_fifo
// Capture-side buffer in front of the SPI slave. Accepted samples from the
// decimator are queued in a show-ahead FIFO. The head byte is presented on
// VAL. The SPI side pulses POP after it has loaded a byte.
//
// Ports:
//   CLK, RST      clock and asynchronous active-high reset
//   SAMPLE        sample byte; SAMPLE_VALID qualifies it
//   DIV           decimation ratio
//   POP           consume the head entry (ignored while EMPTY)
//   CLR_OVF       clear the sticky overflow flag
//   VAL           head entry, 8'h00 while EMPTY
//   EMPTY, FULL   registered occupancy flags
//   LEVEL         registered entry count
//   OVF           sticky lost-sample flag
module val_sample_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_W      = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          SAMPLE,
    input  logic                SAMPLE_VALID,
    input  logic [DIV_W-1:0]    DIV,
    input  logic                POP,
    input  logic                CLR_OVF,
    output logic [7:0]          VAL,
    output logic                EMPTY,
    output logic                FULL,
    output logic [DEPTH_LOG2:0] LEVEL,
    output logic                OVF
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  accepted;
    logic [7:0]            sample_byte;
    logic                  pop_eff;
    logic                  push;
    logic                  overflow;

    sample_decim #(
        .DIV_W(DIV_W)
    ) u_decim (
        .CLK          (CLK),
        .RST          (RST),
        .SAMPLE       (SAMPLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .DIV          (DIV),
        .accepted     (accepted),
        .sample_out   (sample_byte)
    );

    // A pop in the same cycle frees the head slot. Because of that, a full
    // FIFO can still take the accepted sample without losing anything.
    assign pop_eff  = POP && !EMPTY;
    assign push     = accepted && (!FULL || pop_eff);
    assign overflow = accepted && FULL && !pop_eff;

    always_comb begin
        level_next = LEVEL;
        if (push && !pop_eff) begin
            level_next = LEVEL + 1'b1;
        end else if (pop_eff && !push) begin
            level_next = LEVEL - 1'b1;
        end
    end

    // Storage has no reset. Entries outside the occupied window are never
    // presented on VAL.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= sample_byte;
        end
    end

    // The flags are derived from the next count rather than from comparing
    // pointers. This keeps them registered and aligned with the pointer update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            LEVEL  <= '0;
            EMPTY  <= 1'b1;
            FULL   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            LEVEL <= level_next;
            EMPTY <= (level_next == '0);
            FULL  <= (level_next == (DEPTH_LOG2 + 1)'(DEPTH));
        end
    end

    // If a new overflow arrives in the same cycle as a clear request, the
    // new overflow wins. Firmware will then still see the loss.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (overflow) begin
            OVF <= 1'b1;
        end else if (CLR_OVF) begin
            OVF <= 1'b0;
        end
    end

    assign VAL = EMPTY ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_val_sample_fifo.sv
// tb_val_sample_fifo
// Directed bench for val_sample_fifo. Each step drives one cycle of inputs
// and then compares the outputs 1 time unit after the rising edge. The
// expected values are hand-computed.
module tb_val_sample_fifo;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  SAMPLE = 8'h00;
    logic        SAMPLE_VALID = 1'b0;
    logic [15:0] DIV = 16'd0;
    logic        POP = 1'b0;
    logic        CLR_OVF = 1'b0;
    logic [7:0]  VAL;
    logic        EMPTY;
    logic        FULL;
    logic [4:0]  LEVEL;
    logic        OVF;

    int compareCount  = 0;
    int mismatchCount = 0;

    val_sample_fifo #(
        .DEPTH_LOG2(4),
        .DIV_W     (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .SAMPLE       (SAMPLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .DIV          (DIV),
        .POP          (POP),
        .CLR_OVF      (CLR_OVF),
        .VAL          (VAL),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .LEVEL        (LEVEL),
        .OVF          (OVF)
    );

    always #5 CLK = ~CLK;

    // Drives one cycle of inputs, steps past the rising edge and returns the
    // inputs to idle.
    task automatic applyStimulus(input logic sv, input logic [7:0] s,
                                 input logic pop, input logic clr);
        SAMPLE_VALID = sv;
        SAMPLE       = s;
        POP          = pop;
        CLR_OVF      = clr;
        @(posedge CLK);
        #1;
        SAMPLE_VALID = 1'b0;
        SAMPLE       = 8'h00;
        POP          = 1'b0;
        CLR_OVF      = 1'b0;
    endtask

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    initial begin
        // Reset state
        @(posedge CLK);
        #1;
        checkOutput("rst_empty", 32'(EMPTY), 32'd1);
        checkOutput("rst_full",  32'(FULL),  32'd0);
        checkOutput("rst_level", 32'(LEVEL), 32'd0);
        checkOutput("rst_val",   32'(VAL),   32'h00);
        checkOutput("rst_ovf",   32'(OVF),   32'd0);
        RST = 1'b0;

        // Single sample, then pop
        DIV = 16'd0;
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        checkOutput("one_val",   32'(VAL),   32'h11);
        checkOutput("one_empty", 32'(EMPTY), 32'd0);
        checkOutput("one_level", 32'(LEVEL), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pop_val",   32'(VAL),   32'h00);
        checkOutput("pop_empty", 32'(EMPTY), 32'd1);
        checkOutput("pop_level", 32'(LEVEL), 32'd0);

        // DIV=2 keeps samples 1, 4, 7 out of 1..9
        DIV = 16'd2;
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        end
        checkOutput("dec_level", 32'(LEVEL), 32'd3);
        checkOutput("dec_head0", 32'(VAL), 32'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("dec_head1", 32'(VAL), 32'h04);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("dec_head2", 32'(VAL), 32'h07);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("dec_empty", 32'(EMPTY), 32'd1);
        checkOutput("dec_val0",  32'(VAL),   32'h00);

        // Overfill: 17 samples 0x20..0x30, and 0x30 is lost
        DIV = 16'd0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        end
        checkOutput("ovf_full",  32'(FULL),  32'd1);
        checkOutput("ovf_level", 32'(LEVEL), 32'd16);
        checkOutput("ovf_flag",  32'(OVF),   32'd1);
        checkOutput("ovf_head",  32'(VAL),   32'h20);

        // Clear OVF with no overflow in the same cycle
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr_ovf", 32'(OVF), 32'd0);

        // Push and pop together while full
        applyStimulus(1'b1, 8'h31, 1'b1, 1'b0);
        checkOutput("fpp_level", 32'(LEVEL), 32'd16);
        checkOutput("fpp_ovf",   32'(OVF),   32'd0);
        checkOutput("fpp_full",  32'(FULL),  32'd1);
        checkOutput("fpp_head",  32'(VAL),   32'h21);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] expByte;
            expByte = (i < 15) ? 8'(8'h21 + i) : 8'h31;
            checkOutput("drain_val", 32'(VAL), 32'(expByte));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drain_empty", 32'(EMPTY), 32'd1);
        checkOutput("drain_level", 32'(LEVEL), 32'd0);

        // POP while empty has no effect
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("epop_level", 32'(LEVEL), 32'd0);
        checkOutput("epop_empty", 32'(EMPTY), 32'd1);
        checkOutput("epop_val",   32'(VAL),   32'h00);

        // Push and pop together while empty: only the push happens
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("epp_level", 32'(LEVEL), 32'd1);
        checkOutput("epp_val",   32'(VAL),   32'h55);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("epp_drain", 32'(LEVEL), 32'd0);

        // Overflow in the same cycle as CLR_OVF: the set wins
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        checkOutput("fill2_full", 32'(FULL), 32'd1);
        checkOutput("fill2_ovf",  32'(OVF),  32'd0);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
        checkOutput("setwins_ovf",   32'(OVF),   32'd1);
        checkOutput("setwins_level", 32'(LEVEL), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr2_ovf", 32'(OVF), 32'd0);

        // Drain to 5 entries and load the decimator counter, then reset mid-stream
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("mid_level", 32'(LEVEL), 32'd5);
        checkOutput("mid_head",  32'(VAL),   32'h4B);
        DIV = 16'd3;
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
        checkOutput("mid_level6", 32'(LEVEL), 32'd6);
        RST = 1'b1;
        #1;
        checkOutput("arst_level", 32'(LEVEL), 32'd0);
        checkOutput("arst_empty", 32'(EMPTY), 32'd1);
        checkOutput("arst_val",   32'(VAL),   32'h00);
        checkOutput("arst_full",  32'(FULL),  32'd0);
        #1;
        RST = 1'b0;

        // The first valid sample after reset is accepted even with DIV=3
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        checkOutput("post_level", 32'(LEVEL), 32'd1);
        checkOutput("post_val",   32'(VAL),   32'h77);
        applyStimulus(1'b1, 8'h78, 1'b0, 1'b0);
        checkOutput("post_skip", 32'(LEVEL), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
